// File: rtl/dffnrsnq_ctrl_pkg.sv
// Shared types and constants for the dffnrsnq bank init controller.
package dffnrsnq_ctrl_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic CMD_CLR = 1'b0;
  localparam logic CMD_PRE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RECOVER = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/dffnrsnq_ctrl_tmr.sv
// Loadable down-counter with zero flag; reset value is the first pulse-width load.
module dffnrsnq_ctrl_tmr
  import dffnrsnq_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_c_o
);

  logic [CNT_W-1:0] cnt_q;

  assign zero_c_o = (cnt_q == '0);

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && !zero_c_o) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/dffnrsnq_init_ctrl.sv
// Sequences clear/preset of a dffnrsnq register bank: pulse RN or SETN low,
// wait for recovery, then re-enable the bank clock gate.
module dffnrsnq_init_ctrl
  import dffnrsnq_ctrl_pkg::*;
#(
  parameter int unsigned PW_CYC  = 2,
  parameter int unsigned REC_CYC = 2
) (
  input  logic CLK,
  input  logic RN,
  input  logic REQ,
  input  logic CMD,
  output logic ACK,
  output logic BANK_RN,
  output logic BANK_SETN,
  output logic CLK_EN,
  output logic BUSY,
  output logic DONE
);

  localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(PW_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(REC_CYC - 1);

  ctrl_state_e state_q, state_d;
  logic        ack_q, ack_d;
  logic        bank_rn_q, bank_rn_d;
  logic        bank_setn_q, bank_setn_d;
  logic        clk_en_q, clk_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic             tmr_load_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic             tmr_dec_c;
  logic             tmr_zero_c;

  dffnrsnq_ctrl_tmr #(
    .RST_VAL (PW_LOAD)
  ) u_tmr (
    .clk_i      (CLK),
    .rst_n_i    (RN),
    .load_i     (tmr_load_c),
    .load_val_i (tmr_val_c),
    .dec_i      (tmr_dec_c),
    .zero_c_o   (tmr_zero_c)
  );

  // Reset lands in the middle of an implicit clear, so the bank is cleared on power-up.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q     <= ASSERT;
      ack_q       <= 1'b0;
      bank_rn_q   <= 1'b0;
      bank_setn_q <= 1'b1;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      bank_rn_q   <= bank_rn_d;
      bank_setn_q <= bank_setn_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    done_d      = 1'b0;
    bank_rn_d   = bank_rn_q;
    bank_setn_d = bank_setn_q;
    clk_en_d    = clk_en_q;
    busy_d      = busy_q;
    tmr_load_c  = 1'b0;
    tmr_val_c   = '0;
    tmr_dec_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (REQ) begin
          state_d    = ASSERT;
          tmr_load_c = 1'b1;
          tmr_val_c  = PW_LOAD;
          ack_d      = 1'b1;
          busy_d     = 1'b1;
          clk_en_d   = 1'b0;
          if (CMD == CMD_CLR) begin
            bank_rn_d = 1'b0;
          end else begin
            bank_setn_d = 1'b0;
          end
        end
      end
      ASSERT: begin
        if (!tmr_zero_c) begin
          tmr_dec_c = 1'b1;
        end else begin
          state_d     = RECOVER;
          bank_rn_d   = 1'b1;
          bank_setn_d = 1'b1;
          tmr_load_c  = 1'b1;
          tmr_val_c   = REC_LOAD;
        end
      end
      RECOVER: begin
        if (!tmr_zero_c) begin
          tmr_dec_c = 1'b1;
        end else begin
          state_d  = IDLE;
          clk_en_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: release the bank pins, leave the clock gated.
        state_d     = RECOVER;
        bank_rn_d   = 1'b1;
        bank_setn_d = 1'b1;
        clk_en_d    = 1'b0;
        busy_d      = 1'b1;
        tmr_load_c  = 1'b1;
        tmr_val_c   = REC_LOAD;
      end
    endcase
  end

  assign ACK       = ack_q;
  assign BANK_RN   = bank_rn_q;
  assign BANK_SETN = bank_setn_q;
  assign CLK_EN    = clk_en_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_dffnrsnq_init_ctrl.sv
// Bench for dffnrsnq_init_ctrl: two instances (default and PW=3/REC=1) against
// a cycle-offset reference model, with directed and random stimulus.
module tb_dffnrsnq_init_ctrl;
  import dffnrsnq_ctrl_pkg::*;

  localparam int PW_A = 2;
  localparam int REC_A = 2;
  localparam int PW_B = 3;
  localparam int REC_B = 1;

  logic CLK = 1'b0;
  logic RN, REQ, CMD;
  logic ack_a, rn_a, setn_a, clken_a, busy_a, done_a;
  logic ack_b, rn_b, setn_b, clken_b, busy_b, done_b;

  always #5 CLK = ~CLK;

  dffnrsnq_init_ctrl u_dut_a (
    .CLK(CLK), .RN(RN), .REQ(REQ), .CMD(CMD),
    .ACK(ack_a), .BANK_RN(rn_a), .BANK_SETN(setn_a),
    .CLK_EN(clken_a), .BUSY(busy_a), .DONE(done_a)
  );

  dffnrsnq_init_ctrl #(.PW_CYC(PW_B), .REC_CYC(REC_B)) u_dut_b (
    .CLK(CLK), .RN(RN), .REQ(REQ), .CMD(CMD),
    .ACK(ack_b), .BANK_RN(rn_b), .BANK_SETN(setn_b),
    .CLK_EN(clken_b), .BUSY(busy_b), .DONE(done_b)
  );

  int errors = 0;
  int checks = 0;

  // Model: k = cycles since acceptance (0 = idle); k=1 is the cycle after the accepting edge.
  int   k_a, k_b;
  logic cmd_a, cmd_b, ackable_a, ackable_b;

  int cyc_idx;
  int a_rn_lo, a_setn_lo, a_clken_lo, a_dones, a_rn_hi_at, a_clken_hi_at, a_done_at;
  int b_rn_lo, b_setn_lo, b_clken_lo;
  int a_ack_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Returns {ACK, BANK_RN, BANK_SETN, CLK_EN, BUSY, DONE}.
  function automatic logic [5:0] model_out(input int k, input logic cmd, input logic ackable,
                                           input int pw, input int rec);
    logic pin_low, busy;
    pin_low = (k >= 1) && (k <= pw);
    busy    = (k >= 1) && (k <= pw + rec);
    return {(k == 1) && ackable,
            !(pin_low && cmd == CMD_CLR),
            !(pin_low && cmd == CMD_PRE),
            !busy,
            busy,
            k == pw + rec + 1};
  endfunction

  task automatic model_edge(input int pw, input int rec, inout int k, inout logic cmd,
                            inout logic ackable);
    if (!RN) begin
      k = 1; cmd = CMD_CLR; ackable = 1'b0;
    end else if (k >= 1 && k <= pw + rec) begin
      k = k + 1;
    end else if (REQ) begin
      k = 1; cmd = CMD; ackable = 1'b1;
    end else begin
      k = 0;
    end
  endtask

  task automatic model_reset();
    k_a = 1; cmd_a = CMD_CLR; ackable_a = 1'b0;
    k_b = 1; cmd_b = CMD_CLR; ackable_b = 1'b0;
  endtask

  task automatic compare_all();
    check_eq("a_outputs", 32'({ack_a, rn_a, setn_a, clken_a, busy_a, done_a}),
             32'(model_out(k_a, cmd_a, ackable_a, PW_A, REC_A)));
    check_eq("b_outputs", 32'({ack_b, rn_b, setn_b, clken_b, busy_b, done_b}),
             32'(model_out(k_b, cmd_b, ackable_b, PW_B, REC_B)));
    check_eq("a_pins_not_both_low", 32'(rn_a | setn_a), 32'd1);
    check_eq("b_pins_not_both_low", 32'(rn_b | setn_b), 32'd1);
    check_eq("a_clken_pins_high", 32'(!clken_a || (rn_a && setn_a)), 32'd1);
    check_eq("b_clken_pins_high", 32'(!clken_b || (rn_b && setn_b)), 32'd1);
  endtask

  task automatic clear_stats();
    cyc_idx = 0;
    a_rn_lo = 0; a_setn_lo = 0; a_clken_lo = 0; a_dones = 0;
    a_rn_hi_at = 0; a_clken_hi_at = 0; a_done_at = 0;
    b_rn_lo = 0; b_setn_lo = 0; b_clken_lo = 0;
    a_ack_q.delete();
  endtask

  task automatic collect();
    cyc_idx++;
    if (!rn_a) a_rn_lo++;
    if (!setn_a) a_setn_lo++;
    if (!clken_a) a_clken_lo++;
    if (done_a) a_dones++;
    if (rn_a && a_rn_hi_at == 0) a_rn_hi_at = cyc_idx;
    if (clken_a && a_clken_hi_at == 0) a_clken_hi_at = cyc_idx;
    if (done_a && a_done_at == 0) a_done_at = cyc_idx;
    if (ack_a) a_ack_q.push_back(cyc_idx);
    if (!rn_b) b_rn_lo++;
    if (!setn_b) b_setn_lo++;
    if (!clken_b) b_clken_lo++;
  endtask

  task automatic drive_random();
    if (!RN) RN = ($urandom_range(0, 1) == 1);
    else if ($urandom_range(0, 31) == 0) RN = 1'b0;
    REQ = ($urandom_range(0, 9) < 7);
    CMD = 1'($urandom_range(0, 1));
    if (RN && $urandom_range(0, 63) == 0) begin
      #2;
      RN = 1'b0;
      model_reset();
      #1;
      compare_all();
    end
  endtask

  task automatic step(input bit rnd);
    @(posedge CLK);
    model_edge(PW_A, REC_A, k_a, cmd_a, ackable_a);
    model_edge(PW_B, REC_B, k_b, cmd_b, ackable_b);
    #1;
    compare_all();
    collect();
    if (rnd) drive_random();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    REQ = 1'b0;
    RN  = 1'b1;
    while ((busy_a || busy_b) && n < 50) begin
      step(1'b0);
      n++;
    end
    check_eq("idle_timeout", 32'(busy_a | busy_b), 32'd0);
  endtask

  initial begin
    RN = 1'b1; REQ = 1'b0; CMD = 1'b0;
    clear_stats();
    model_reset();

    // Asynchronous reset, checked before any clock edge.
    #2 RN = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (3) step(1'b0);

    RN = 1'b1;
    clear_stats();
    repeat (6) step(1'b0);
    check_eq("rst_rn_rise_edge", 32'(a_rn_hi_at), 32'd2);
    check_eq("rst_done_edge", 32'(a_done_at), 32'd4);
    check_eq("rst_clken_edge", 32'(a_clken_hi_at), 32'd4);
    check_eq("rst_ack_count", 32'(a_ack_q.size()), 32'd0);

    // Single clear request on the default instance.
    wait_idle();
    REQ = 1'b1; CMD = CMD_CLR;
    clear_stats();
    step(1'b0);
    REQ = 1'b0;
    repeat (6) step(1'b0);
    check_eq("clr_ack_count", 32'(a_ack_q.size()), 32'd1);
    check_eq("clr_ack_cycle", 32'(a_ack_q[0]), 32'd1);
    check_eq("clr_rn_low_cycles", 32'(a_rn_lo), 32'd2);
    check_eq("clr_setn_low_cycles", 32'(a_setn_lo), 32'd0);
    check_eq("clr_clken_low_cycles", 32'(a_clken_lo), 32'd4);
    check_eq("clr_done_cycle", 32'(a_done_at), 32'd5);

    // Preset on the PW=3/REC=1 instance.
    wait_idle();
    REQ = 1'b1; CMD = CMD_PRE;
    clear_stats();
    step(1'b0);
    REQ = 1'b0;
    repeat (6) step(1'b0);
    check_eq("pre_setn_low_cycles", 32'(b_setn_lo), 32'd3);
    check_eq("pre_clken_low_cycles", 32'(b_clken_lo), 32'd4);
    check_eq("pre_rn_low_cycles", 32'(b_rn_lo), 32'd0);

    // REQ held high with CMD toggling: back-to-back operations.
    wait_idle();
    REQ = 1'b1;
    clear_stats();
    repeat (15) begin
      step(1'b0);
      CMD = ~CMD;
    end
    REQ = 1'b0;
    check_eq("b2b_ack_count", 32'(a_ack_q.size()), 32'd3);
    check_eq("b2b_done_count", 32'(a_dones), 32'd3);
    check_eq("b2b_ack_gap0", 32'(a_ack_q[1] - a_ack_q[0]), 32'(PW_A + REC_A + 1));
    check_eq("b2b_ack_gap1", 32'(a_ack_q[2] - a_ack_q[1]), 32'(PW_A + REC_A + 1));

    // Reset falls mid-preset without a clock edge.
    wait_idle();
    REQ = 1'b1; CMD = CMD_PRE;
    step(1'b0);
    REQ = 1'b0;
    step(1'b0);
    check_eq("abort_setn_before", 32'(setn_b), 32'd0);
    #3 RN = 1'b0;
    model_reset();
    #1;
    check_eq("abort_setn_rises", 32'(setn_b), 32'd1);
    check_eq("abort_rn_falls", 32'(rn_b), 32'd0);
    compare_all();
    repeat (2) step(1'b0);
    RN = 1'b1;
    wait_idle();

    // Random REQ/CMD/RN traffic against the model.
    clear_stats();
    repeat (800) step(1'b1);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dffnrsnq_init_ctrl.md
DFFNRSNQ_INIT_CTRL -- requirements
Module: dffnrsnq_init_ctrl

Interface
REQ-001 SHALL have parameter PW_CYC, default 2: number of cycles BANK_RN or BANK_SETN is held low; legal range 1..15.
REQ-002 SHALL have parameter REC_CYC, default 2: number of cycles after release before CLK_EN rises; legal range 1..15.
REQ-003 SHALL have port CLK, input, 1: the only clock; all state changes occur on the rising edge.
REQ-004 SHALL have port RN, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port REQ, input, 1: level request for a bank init; held high until ACK.
REQ-006 SHALL have port CMD, input, 1: 0 = clear the bank to 0 via BANK_RN, 1 = preset the bank to 1 via BANK_SETN; sampled with REQ.
REQ-007 SHALL have port ACK, output, 1: one-cycle pulse marking request acceptance.
REQ-008 SHALL have port BANK_RN, output, 1: active-low reset driven to the RN pins of a dffnrsnq register bank.
REQ-009 SHALL have port BANK_SETN, output, 1: active-low set driven to the SETN pins of the bank.
REQ-010 SHALL have port CLK_EN, output, 1: enable for the bank's CLKN clock gate; high means the bank may be clocked.
REQ-011 SHALL have port BUSY, output, 1: high whenever the FSM is not IDLE.
REQ-012 SHALL have port DONE, output, 1: one-cycle pulse on return to IDLE.

Function
REQ-013 SHALL have all outputs registered, with no combinational path from any input to any output.
REQ-014 SHALL implement FSM states IDLE, ASSERT and RECOVER, plus a 4-bit down-counter cnt.
REQ-015 On an edge in IDLE with REQ=1, SHALL:
- go to ASSERT with cnt<=PW_CYC-1;
- set ACK<=1 and BUSY<=1;
- set CLK_EN<=0;
- drive BANK_RN<=0 if CMD=0, else BANK_SETN<=0.
REQ-016 In ASSERT with cnt!=0, SHALL decrement cnt; with cnt==0, SHALL drive both BANK_RN and BANK_SETN to 1 and go to RECOVER with cnt<=REC_CYC-1.
REQ-017 In RECOVER with cnt!=0, SHALL decrement cnt; with cnt==0, SHALL go to IDLE with CLK_EN<=1, BUSY<=0 and DONE<=1.
REQ-018 SHALL hold the selected bank pin low for exactly PW_CYC cycles and CLK_EN low for exactly PW_CYC+REC_CYC cycles per request.
REQ-019 SHALL never have BANK_RN=0 and BANK_SETN=0 in the same cycle, and SHALL never release either pin while CLK_EN=1.
REQ-020 SHALL ignore REQ while BUSY=1, without generating ACK or sampling CMD.
REQ-021 A REQ that is still high in the cycle DONE is high SHALL be accepted on the following edge, giving back-to-back operation with one IDLE cycle between requests.
REQ-022 SHALL pulse ACK and DONE for exactly one cycle each, with ACK=0 and DONE=0 otherwise.

Reset
REQ-023 SHALL, while RN=0 and regardless of CLK or current state, hold: state=ASSERT, cnt=PW_CYC-1, BANK_RN=0, BANK_SETN=1, CLK_EN=0, BUSY=1, ACK=0, DONE=0.
REQ-024 After RN rises, SHALL complete an implicit clear sequence (ASSERT, then RECOVER, then IDLE with a DONE pulse) and SHALL NOT generate ACK.
REQ-025 RN assertion mid-operation, including a preset in progress, SHALL abort the operation immediately; BANK_SETN SHALL rise in the same instant BANK_RN falls.
REQ-026 RN deassertion SHALL be synchronized to CLK upstream; this block contains no reset synchronizer.

Structure
REQ-027 A shared package dffnrsnq_ctrl_pkg SHALL hold:
- the state enum (IDLE, ASSERT, RECOVER);
- CMD_CLR=0 and CMD_PRE=1;
- the counter width constant of 4.
REQ-028 SHALL use exactly one sub-module, dffnrsnq_ctrl_tmr: a loadable 4-bit down-counter with async active-low reset and a zero flag. All other logic SHALL be flat.

Verification
REQ-029 Reset, defaults: RN low for 3 cycles, then high -> BANK_RN low through 2 edges after release, CLK_EN rises and DONE pulses at the 4th edge after release, and ACK stays 0.
REQ-030 Clear request: REQ=1, CMD=0 at edge 0 -> ACK=1 in cycle 1, BANK_RN=0 during cycles 1-2, CLK_EN=1 and DONE=1 in cycle 5 (edge 4), BANK_SETN=1 throughout.
REQ-031 Preset with PW_CYC=3, REC_CYC=1: REQ=1, CMD=1 -> BANK_SETN low for exactly 3 cycles, CLK_EN low for exactly 4 cycles, BANK_RN=1 throughout.
REQ-032 Busy and back-to-back: REQ held high continuously with CMD toggled mid-operation -> exactly one ACK per operation, CMD sampled only at ACK, one IDLE cycle between operations.
REQ-033 Reset mid-preset: RN falls during ASSERT of a preset -> BANK_SETN=1 and BANK_RN=0 immediately, with no clock edge required, and the assertion checking that the two pins are never both low passes.
REQ-034 Property check over random REQ/CMD/RN stimulus:
- BANK_RN and BANK_SETN are never both 0;
- CLK_EN=1 implies BANK_RN=1 and BANK_SETN=1;
- BUSY equals (state != IDLE).
